// File: rtl/pcm_to_pdm_modulator_if.sv
// PCM sample stream port: a valid/ready push interface.
// Signal names are written from the modulator's point of view.
interface pcm_to_pdm_modulator_if #(
  parameter int PCM_WIDTH = 16
);
  logic [PCM_WIDTH-1:0] pcm_data_i;
  logic                 pcm_valid_i;
  logic                 pcm_ready_o;

  modport master (
    output pcm_data_i,
    output pcm_valid_i,
    input  pcm_ready_o
  );

  modport slave (
    input  pcm_data_i,
    input  pcm_valid_i,
    output pcm_ready_o
  );
endinterface

// File: rtl/pcm_to_pdm_modulator.sv
// First-order sigma-delta modulator: signed PCM samples from a small FIFO become a 1-bit PDM
// stream with its own bit clock. Each sample is held for OSR PDM bits.
module pcm_to_pdm_modulator #(
  parameter int PCM_WIDTH  = 16,
  parameter int CLK_DIV    = 100,
  parameter int OSR        = 64,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                         clk_i,
  input  logic                         rst_n_i,
  input  logic                         enable_i,
  pcm_to_pdm_modulator_if.slave        pcm_if,
  output logic                         pdm_clk_o,
  output logic                         pdm_data_o,
  output logic                         fifo_empty_o,
  output logic                         underflow_o
);

  localparam int DIV_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam int OSR_W = (OSR > 2) ? $clog2(OSR) : 1;
  localparam int PTR_W = (FIFO_DEPTH > 2) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(CLK_DIV / 2);
  localparam logic [OSR_W-1:0] OSR_LAST = OSR_W'(OSR - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // Offset-binary view of a two's-complement sample: -full scale maps to 0.
  function automatic logic [PCM_WIDTH-1:0] to_offset(input logic [PCM_WIDTH-1:0] s);
    return {~s[PCM_WIDTH-1], s[PCM_WIDTH-2:0]};
  endfunction

  state_t                 r_state;
  logic [DIV_W-1:0]       r_div_cnt;
  logic [OSR_W-1:0]       r_osr_cnt;
  logic [PCM_WIDTH-1:0]   r_acc;
  logic [PCM_WIDTH-1:0]   r_cur_sample;
  logic                   r_pdm_clk;
  logic                   r_pdm_data;
  logic                   r_underflow;

  logic [PCM_WIDTH-1:0]   r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]       r_wr_ptr;
  logic [PTR_W-1:0]       r_rd_ptr;
  logic [CNT_W-1:0]       r_count;
  logic                   r_ready;
  logic                   r_empty;

  logic                   w_tick;
  logic                   w_boundary;
  logic                   w_push;
  logic                   w_pop;
  logic [DIV_W-1:0]       w_div_nxt;
  logic [OSR_W-1:0]       w_osr_nxt;
  logic [PCM_WIDTH-1:0]   w_sample;
  logic [PCM_WIDTH:0]     w_sum;
  logic [CNT_W-1:0]       w_count_nxt;

  // A tick is withheld on the disabling edge so a sample is never popped and then discarded.
  assign w_tick     = (r_state == ST_RUN) && enable_i && (r_div_cnt == DIV_LAST);
  assign w_boundary = w_tick && (r_osr_cnt == '0);
  assign w_push     = pcm_if.pcm_valid_i && r_ready;
  assign w_pop      = w_boundary && !r_empty;

  // Next counters, the sample used for this tick and the accumulator sum.
  always_comb begin
    w_div_nxt = '0;
    w_osr_nxt = '0;
    w_sample  = r_cur_sample;
    if (r_div_cnt == DIV_LAST) begin
      w_div_nxt = '0;
    end else begin
      w_div_nxt = r_div_cnt + DIV_W'(1);
    end
    if (r_osr_cnt == OSR_LAST) begin
      w_osr_nxt = '0;
    end else begin
      w_osr_nxt = r_osr_cnt + OSR_W'(1);
    end
    if (w_boundary) begin
      if (r_empty) begin
        w_sample = '0;
      end else begin
        w_sample = r_mem[r_rd_ptr];
      end
    end else begin
      w_sample = r_cur_sample;
    end
    w_sum = {1'b0, r_acc} + {1'b0, to_offset(w_sample)};
  end

  // FIFO occupancy after this cycle's push/pop.
  always_comb begin
    w_count_nxt = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_nxt = r_count + CNT_W'(1);
      2'b01:   w_count_nxt = r_count - CNT_W'(1);
      default: w_count_nxt = r_count;
    endcase
  end

  // Modulator FSM: bit clock divider, oversampling counter, accumulator and registered outputs.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state      <= ST_IDLE;
      r_div_cnt    <= '0;
      r_osr_cnt    <= '0;
      r_acc        <= '0;
      r_cur_sample <= '0;
      r_pdm_clk    <= 1'b0;
      r_pdm_data   <= 1'b0;
      r_underflow  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_div_cnt   <= '0;
          r_osr_cnt   <= '0;
          r_acc       <= '0;
          r_pdm_clk   <= 1'b0;
          r_pdm_data  <= 1'b0;
          r_underflow <= 1'b0;
          if (enable_i) begin
            r_state <= ST_RUN;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_RUN: begin
          if (!enable_i) begin
            r_state     <= ST_IDLE;
            r_div_cnt   <= '0;
            r_osr_cnt   <= '0;
            r_acc       <= '0;
            r_pdm_clk   <= 1'b0;
            r_pdm_data  <= 1'b0;
            r_underflow <= 1'b0;
          end else begin
            r_state     <= ST_RUN;
            r_div_cnt   <= w_div_nxt;
            r_pdm_clk   <= (w_div_nxt >= DIV_HALF);
            r_underflow <= w_boundary && r_empty;
            if (w_tick) begin
              r_osr_cnt    <= w_osr_nxt;
              r_acc        <= w_sum[PCM_WIDTH-1:0];
              r_pdm_data   <= w_sum[PCM_WIDTH];
              r_cur_sample <= w_sample;
            end else begin
              r_osr_cnt    <= r_osr_cnt;
              r_acc        <= r_acc;
              r_pdm_data   <= r_pdm_data;
              r_cur_sample <= r_cur_sample;
            end
          end
        end
        default: begin
          r_state     <= ST_IDLE;
          r_div_cnt   <= '0;
          r_osr_cnt   <= '0;
          r_acc       <= '0;
          r_pdm_clk   <= 1'b0;
          r_pdm_data  <= 1'b0;
          r_underflow <= 1'b0;
        end
      endcase
    end
  end

  // FIFO pointers, occupancy and the registered ready/empty flags.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_ready  <= 1'b1;
      r_empty  <= 1'b1;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end else begin
        r_wr_ptr <= r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end else begin
        r_rd_ptr <= r_rd_ptr;
      end
      r_count <= w_count_nxt;
      r_ready <= (w_count_nxt != CNT_FULL);
      r_empty <= (w_count_nxt == '0);
    end
  end

  // Sample storage; a reset flushes it through the pointers, so the array itself is not cleared.
  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= pcm_if.pcm_data_i;
    end
  end

  assign pcm_if.pcm_ready_o = r_ready;
  assign pdm_clk_o          = r_pdm_clk;
  assign pdm_data_o         = r_pdm_data;
  assign fifo_empty_o       = r_empty;
  assign underflow_o        = r_underflow;

endmodule

// File: tb/tb_pcm_to_pdm_modulator.sv
// Directed bench for pcm_to_pdm_modulator with CLK_DIV=4, OSR=8, FIFO_DEPTH=8.
// Bit patterns are listed oldest bit in bit 0.
module tb_pcm_to_pdm_modulator;
  localparam int PW = 16;
  localparam int CD = 4;
  localparam int OS = 8;
  localparam int FD = 8;

  logic clk_i = 1'b0;
  logic rst_n_i;
  logic enable_i;
  logic pdm_clk_o;
  logic pdm_data_o;
  logic fifo_empty_o;
  logic underflow_o;

  int n_chk  = 0;
  int n_fail = 0;

  pcm_to_pdm_modulator_if #(.PCM_WIDTH(PW)) u_pcm_if ();

  pcm_to_pdm_modulator #(
    .PCM_WIDTH  (PW),
    .CLK_DIV    (CD),
    .OSR        (OS),
    .FIFO_DEPTH (FD)
  ) u_dut (
    .clk_i        (clk_i),
    .rst_n_i      (rst_n_i),
    .enable_i     (enable_i),
    .pcm_if       (u_pcm_if),
    .pdm_clk_o    (pdm_clk_o),
    .pdm_data_o   (pdm_data_o),
    .fifo_empty_o (fifo_empty_o),
    .underflow_o  (underflow_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic push(input logic [15:0] v);
    u_pcm_if.pcm_data_i  = v;
    u_pcm_if.pcm_valid_i = 1'b1;
    step();
    u_pcm_if.pcm_valid_i = 1'b0;
  endtask

  task automatic start_run();
    enable_i = 1'b1;
    step();
  endtask

  task automatic stop_run();
    enable_i = 1'b0;
    step();
  endtask

  // First bit after first_wait cycles, then one bit every CD cycles.
  task automatic collect_bits(input int n, input int first_wait, output logic [127:0] b);
    b = '0;
    for (int i = 0; i < n; i++) begin
      int w;
      w = (i == 0) ? first_wait : CD;
      repeat (w) step();
      b[i] = pdm_data_o;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached before end of test");
    $fatal(1);
  end

  initial begin
    logic [127:0] bits;
    logic [127:0] rest;
    logic [3:0]   clk_seq;
    logic [3:0]   dat_seq;
    logic [15:0]  t4_val [9];
    logic [7:0]   t4_pat [9];
    int           k;

    t4_val = '{16'h2000, 16'hA000, 16'h6000, 16'hE000, 16'h0000,
               16'h4000, 16'h8000, 16'hC000, 16'h2000};
    t4_pat = '{8'hDA, 8'h80, 8'hFE, 8'hA4, 8'hAA, 8'hEE, 8'h00, 8'h88, 8'hDA};

    rst_n_i              = 1'b0;
    enable_i             = 1'b0;
    u_pcm_if.pcm_data_i  = 16'h0000;
    u_pcm_if.pcm_valid_i = 1'b0;
    repeat (3) step();
    check_eq("rst_pdm_clk",   pdm_clk_o,            1'b0);
    check_eq("rst_pdm_data",  pdm_data_o,           1'b0);
    check_eq("rst_ready",     u_pcm_if.pcm_ready_o, 1'b1);
    check_eq("rst_empty",     fifo_empty_o,         1'b1);
    check_eq("rst_underflow", underflow_o,          1'b0);
    rst_n_i = 1'b1;
    step();

    // T2: zero sample, bit clock shape and data timing
    push(16'h0000);
    start_run();
    collect_bits(8, CD, bits);
    check_eq("t2_zero_bits", bits[7:0], 8'hAA);
    for (int i = 0; i < 4; i++) begin
      step();
      clk_seq[i] = pdm_clk_o;
      dat_seq[i] = pdm_data_o;
    end
    check_eq("t2_clk_shape", clk_seq, 4'b0110);
    check_eq("t2_data_hold", dat_seq, 4'b0111);
    check_eq("t2_underflow", underflow_o, 1'b1);
    step();
    check_eq("t2_underflow_pulse", underflow_o, 1'b0);
    stop_run();
    check_eq("t2_idle_clk",  pdm_clk_o,  1'b0);
    check_eq("t2_idle_data", pdm_data_o, 1'b0);

    // T3: density for several levels, each from acc=0
    push(16'h4000);
    start_run();
    collect_bits(8, CD, bits);
    check_eq("t3_half_pos", bits[7:0], 8'hEE);
    stop_run();
    push(16'h8000);
    start_run();
    collect_bits(8, CD, bits);
    check_eq("t3_neg_full", bits[7:0], 8'h00);
    stop_run();
    push(16'h7FFF);
    start_run();
    collect_bits(8, CD, bits);
    check_eq("t3_pos_full", bits[7:0], 8'hFE);
    stop_run();
    push(16'hC000);
    start_run();
    collect_bits(8, CD, bits);
    check_eq("t3_half_neg", bits[7:0], 8'h88);
    stop_run();

    // T4: fill in IDLE, stall the ninth, then play all in order
    for (int i = 0; i < 8; i++) begin
      u_pcm_if.pcm_data_i  = t4_val[i];
      u_pcm_if.pcm_valid_i = 1'b1;
      step();
    end
    check_eq("t4_ready_full", u_pcm_if.pcm_ready_o, 1'b0);
    check_eq("t4_not_empty",  fifo_empty_o,         1'b0);
    u_pcm_if.pcm_data_i = t4_val[8];
    step();
    step();
    check_eq("t4_ready_stall", u_pcm_if.pcm_ready_o, 1'b0);
    start_run();
    repeat (3) step();
    check_eq("t4_ready_before_pop", u_pcm_if.pcm_ready_o, 1'b0);
    step();
    check_eq("t4_ready_after_pop", u_pcm_if.pcm_ready_o, 1'b1);
    bits    = '0;
    bits[0] = pdm_data_o;
    step();
    u_pcm_if.pcm_valid_i = 1'b0;
    check_eq("t4_ready_refull", u_pcm_if.pcm_ready_o, 1'b0);
    collect_bits(71, CD - 1, rest);
    bits[71:1] = rest[70:0];
    for (int i = 0; i < 9; i++) begin
      check_eq($sformatf("t4_sample%0d", i), bits[8*i +: 8], t4_pat[i]);
    end
    stop_run();

    // T5: empty FIFO underflows at every sample boundary
    start_run();
    repeat (4) step();
    check_eq("t5_underflow_first", underflow_o, 1'b1);
    check_eq("t5_zero_first_bit",  pdm_data_o,  1'b0);
    step();
    check_eq("t5_underflow_clear", underflow_o, 1'b0);
    k = 0;
    for (int j = 1; j <= 40; j++) begin
      step();
      if (underflow_o === 1'b1) begin
        k = j;
        break;
      end
    end
    check_eq("t5_underflow_period", k, 31);
    push(16'h4000);
    collect_bits(15, CD - 1, bits);
    check_eq("t5_zero_tail",   bits[6:0],  7'h55);
    check_eq("t5_late_sample", bits[14:7], 8'hEE);
    stop_run();

    // T6: disable mid-sample discards it and clears acc
    push(16'h4000);
    push(16'h2000);
    start_run();
    collect_bits(3, CD, bits);
    check_eq("t6_first_bits", bits[2:0], 3'b110);
    step();
    step();
    check_eq("t6_clk_high", pdm_clk_o, 1'b1);
    stop_run();
    check_eq("t6_idle_clk",  pdm_clk_o,    1'b0);
    check_eq("t6_idle_data", pdm_data_o,   1'b0);
    check_eq("t6_fifo_kept", fifo_empty_o, 1'b0);
    check_eq("t6_ready",     u_pcm_if.pcm_ready_o, 1'b1);
    start_run();
    collect_bits(8, CD, bits);
    check_eq("t6_second_sample", bits[7:0], 8'hDA);

    // T1: asynchronous reset in the middle of a run
    push(16'h1234);
    push(16'h5678);
    check_eq("t1_pre_clk",   pdm_clk_o,    1'b1);
    check_eq("t1_pre_data",  pdm_data_o,   1'b1);
    check_eq("t1_pre_empty", fifo_empty_o, 1'b0);
    #2;
    rst_n_i = 1'b0;
    #1;
    check_eq("t1_clk",       pdm_clk_o,            1'b0);
    check_eq("t1_data",      pdm_data_o,           1'b0);
    check_eq("t1_ready",     u_pcm_if.pcm_ready_o, 1'b1);
    check_eq("t1_empty",     fifo_empty_o,         1'b1);
    check_eq("t1_underflow", underflow_o,          1'b0);
    enable_i = 1'b0;
    step();
    rst_n_i = 1'b1;
    step();
    check_eq("t1_flushed", fifo_empty_o, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
